// File: rtl/posit_pkg.sv
// Shared definitions for the posit rounding pipeline.
// Patterns are built at a fixed maximum width and sliced by each user.
package posit_pkg;

  localparam int PMAX  = 64;
  localparam int WW    = PMAX + 2;
  localparam int N_DEF = 32;
  localparam int KMAX  = N_DEF - 2;
  localparam int KMIN  = -(N_DEF - 2);

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          nar;
    logic          rtz;
    logic          sat;
    logic          sticky;
    logic [WW-1:0] win;
  } s1_pay_t;

  function automatic int kmax(input int n);
    return n - 2;
  endfunction

  function automatic int kmin(input int n);
    return -(n - 2);
  endfunction

  function automatic logic [PMAX-1:0] nar_pat(input int n);
    return PMAX'(1) << (n - 1);
  endfunction

  function automatic logic [PMAX-1:0] maxpos_pat(input int n);
    return (PMAX'(1) << (n - 1)) - PMAX'(1);
  endfunction

  function automatic logic [PMAX-1:0] minpos_pat();
    return PMAX'(1);
  endfunction

endpackage

// File: rtl/posit_regime_pack.sv
// Builds the regime run and shifts {exp, frac} behind it into the
// (N-1)+2 bit rounding window; everything further down folds into sticky.
module posit_regime_pack #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int FW = N,
  parameter int KW = $clog2(N) + 2
) (
  input  logic signed [KW-1:0] k,
  input  logic [ES-1:0]        exp,
  input  logic [FW-1:0]        frac,
  input  logic                 sticky,
  output logic [N:0]           win,
  output logic                 sticky_out
);

  localparam int M = N + ES + FW;

  logic          fill;
  logic [KW-1:0] run;
  logic [M-1:0]  body;
  logic [M-1:0]  mask;
  logic [M-1:0]  r;

  // Terminator bit leads the body; the run of fill bits is shifted in.
  always_comb begin
    fill = ~k[KW-1];
    run  = fill ? KW'(k + KW'(1)) : KW'(-k);
    body = {~fill, exp, frac, {(N-1){1'b0}}};
    mask = ~({M{1'b1}} >> run);
    r    = (body >> run) | (fill ? mask : '0);
    win  = r[M-1 -: N+1];
    sticky_out = sticky | (|r[M-N-2:0]);
  end

endmodule

// File: rtl/posit_round_pipe.sv
// Two-stage posit encoder: clamp/pack, then round/sign with
// valid/ready flow control between stages.
module posit_round_pipe
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int FW = N,
  parameter int KW = $clog2(N) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic                 in_zero,
  input  logic                 in_nar,
  input  logic signed [KW-1:0] in_k,
  input  logic [ES-1:0]        in_exp,
  input  logic [FW-1:0]        in_frac,
  input  logic                 in_sticky,
  input  logic                 in_rtz,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit,
  output logic                 out_inexact,
  output logic                 out_sat
);

  localparam logic signed [KW-1:0] K_HI = KW'(kmax(N));
  localparam logic signed [KW-1:0] K_LO = KW'(kmin(N));
  localparam logic [N-1:0] P_NAR = N'(nar_pat(N));
  localparam logic [N-1:0] P_MAX = N'(maxpos_pat(N));
  localparam logic [N-1:0] P_MIN = N'(minpos_pat());

  logic                 s1_valid;
  logic                 s1_adv;
  logic                 s2_adv;
  logic signed [KW-1:0] k_c;
  logic                 sat_c;
  logic [N:0]           pk_win;
  logic                 pk_sticky;
  s1_pay_t              s1_d;
  s1_pay_t              s1_q;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    k_c   = in_k;
    sat_c = 1'b0;
    if (in_k > K_HI) begin
      k_c   = K_HI;
      sat_c = 1'b1;
    end else if (in_k < K_LO) begin
      k_c   = K_LO;
      sat_c = 1'b1;
    end
  end

  posit_regime_pack #(
    .N (N),
    .ES(ES),
    .FW(FW),
    .KW(KW)
  ) u_pack (
    .k         (k_c),
    .exp       (in_exp),
    .frac      (in_frac),
    .sticky    (in_sticky),
    .win       (pk_win),
    .sticky_out(pk_sticky)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.zero   = in_zero;
    s1_d.nar    = in_nar;
    s1_d.rtz    = in_rtz;
    s1_d.sat    = sat_c;
    s1_d.sticky = pk_sticky;
    s1_d.win    = {pk_win, {(WW-N-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [N-2:0] kept;
  logic         g;
  logic         s;
  logic         inc;
  logic [N-1:0] sum;
  logic [N-2:0] mag;
  logic [N-1:0] pos;
  logic [N-1:0] r_posit;
  logic         r_inx;
  logic         r_sat;

  // Window sits MSB-aligned in the payload; all lower bits feed S.
  always_comb begin
    kept = s1_q.win[WW-1 -: N-1];
    g    = s1_q.win[WW-N];
    s    = s1_q.sticky | (|s1_q.win[WW-N-1:0]);
    inc  = ~s1_q.rtz & g & (s | kept[0]);
    sum  = {1'b0, kept} + N'(inc);
    mag  = sum[N-1] ? P_MAX[N-2:0] : sum[N-2:0];
    if (mag == '0) mag = P_MIN[N-2:0];
    pos  = {1'b0, mag};
    if (s1_q.sign) pos = -pos;
    r_posit = pos;
    r_inx   = g | s;
    r_sat   = s1_q.sat;
    if (s1_q.nar) begin
      r_posit = P_NAR;
      r_inx   = 1'b0;
      r_sat   = 1'b0;
    end else if (s1_q.zero) begin
      r_posit = '0;
      r_inx   = 1'b0;
      r_sat   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_posit   <= '0;
      out_inexact <= 1'b0;
      out_sat     <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_posit   <= r_posit;
        out_inexact <= r_inx;
        out_sat     <= r_sat;
      end
    end
  end

endmodule

// File: tb/tb_posit_round_pipe.sv
// Bench for posit_round_pipe at N=16, ES=1, FW=16 with a bit-list
// reference encoder and a queue scoreboard.
module tb_posit_round_pipe;

  localparam int N  = 16;
  localparam int ES = 1;
  localparam int FW = 16;
  localparam int KW = $clog2(N) + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_sign = 1'b0;
  logic                 in_zero = 1'b0;
  logic                 in_nar = 1'b0;
  logic signed [KW-1:0] in_k = '0;
  logic [ES-1:0]        in_exp = '0;
  logic [FW-1:0]        in_frac = '0;
  logic                 in_sticky = 1'b0;
  logic                 in_rtz = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [N-1:0]         out_posit;
  logic                 out_inexact;
  logic                 out_sat;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  posit_round_pipe #(
    .N (N),
    .ES(ES),
    .FW(FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_zero    (in_zero),
    .in_nar     (in_nar),
    .in_k       (in_k),
    .in_exp     (in_exp),
    .in_frac    (in_frac),
    .in_sticky  (in_sticky),
    .in_rtz     (in_rtz),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_posit  (out_posit),
    .out_inexact(out_inexact),
    .out_sat    (out_sat)
  );

  typedef struct {
    bit        sign;
    bit        zero;
    bit        nar;
    bit        rtz;
    bit        sticky;
    int        k;
    bit        e;
    bit [15:0] frac;
  } beat_t;

  typedef struct {
    bit [15:0] p;
    bit        inx;
    bit        sat;
  } res_t;

  // Reference: write the posit bit string out, then round the first 15 bits.
  function automatic res_t model(beat_t b);
    res_t r;
    bit   q[$];
    int   k;
    int   kept;
    int   val;
    bit   g;
    bit   s;
    bit   up;
    r.p = 16'h0000;
    r.inx = 1'b0;
    r.sat = 1'b0;
    if (b.nar) begin
      r.p = 16'h8000;
      return r;
    end
    if (b.zero) return r;
    k = b.k;
    if (k > N - 2) begin k = N - 2; r.sat = 1'b1; end
    if (k < -(N - 2)) begin k = -(N - 2); r.sat = 1'b1; end
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    q.push_back(b.e);
    for (int i = 15; i >= 0; i--) q.push_back(b.frac[i]);
    kept = 0;
    for (int i = 0; i < N - 1; i++)
      kept = kept * 2 + ((i < q.size()) ? int'(q[i]) : 0);
    g = (N - 1 < q.size()) ? q[N-1] : 1'b0;
    s = b.sticky;
    for (int i = N; i < q.size(); i++) s = s | q[i];
    up = !b.rtz && g && (s || (kept % 2 == 1));
    val = kept + int'(up);
    if (val > 32767) val = 32767;
    if (val == 0) val = 1;
    r.p = b.sign ? 16'((65536 - val) % 65536) : 16'(val);
    r.inx = g | s;
    return r;
  endfunction

  function automatic beat_t mk(int k, bit e, bit [15:0] f, bit sign,
                               bit rtz, bit zero, bit nar);
    beat_t b;
    b.k = k; b.e = e; b.frac = f; b.sign = sign;
    b.rtz = rtz; b.zero = zero; b.nar = nar; b.sticky = 1'b0;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.k      = int'($urandom_range(0, 44)) - 22;
    b.e      = 1'($urandom);
    b.frac   = 16'($urandom);
    b.sign   = 1'($urandom);
    b.rtz    = 1'($urandom);
    b.sticky = 1'($urandom);
    b.zero   = ($urandom_range(0, 15) == 0);
    b.nar    = ($urandom_range(0, 15) == 0);
    return b;
  endfunction

  task automatic drive(beat_t b);
    in_sign   = b.sign;
    in_zero   = b.zero;
    in_nar    = b.nar;
    in_rtz    = b.rtz;
    in_sticky = b.sticky;
    in_k      = KW'(b.k);
    in_exp    = b.e;
    in_frac   = b.frac;
  endtask

  task automatic run_single(input beat_t b, output res_t got, output int lat);
    @(negedge clk);
    drive(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    got.p   = out_posit;
    got.inx = out_inexact;
    got.sat = out_sat;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
    else passes++;
    checks++;
    if (out_posit !== 16'h0) $display("FAIL rst_posit got %h want 0000", out_posit);
    else passes++;
    checks++;
    if ({out_inexact, out_sat} !== 2'b00)
      $display("FAIL rst_flags got %b%b want 00", out_inexact, out_sat);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready);
    else passes++;
  endtask

  task automatic test_directed();
    beat_t bs[11];
    res_t  ex[11];
    res_t  got;
    int    lat;
    bs[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0);   ex[0]  = '{16'h4000, 0, 0};
    bs[1]  = mk(0, 0, 16'h0000, 1, 0, 0, 0);   ex[1]  = '{16'hC000, 0, 0};
    bs[2]  = mk(0, 0, 16'h0008, 0, 0, 0, 0);   ex[2]  = '{16'h4000, 1, 0};
    bs[3]  = mk(0, 0, 16'h0018, 0, 0, 0, 0);   ex[3]  = '{16'h4002, 1, 0};
    bs[4]  = mk(0, 0, 16'h0018, 0, 1, 0, 0);   ex[4]  = '{16'h4001, 1, 0};
    bs[5]  = mk(20, 0, 16'h0000, 0, 0, 0, 0);  ex[5]  = '{16'h7FFF, 0, 1};
    bs[6]  = mk(-20, 0, 16'h0000, 0, 0, 0, 0); ex[6]  = '{16'h0001, 0, 1};
    bs[7]  = mk(14, 1, 16'hFFFF, 0, 0, 0, 0);  ex[7]  = '{16'h7FFF, 1, 0};
    bs[8]  = mk(3, 1, 16'h1234, 1, 0, 1, 0);   ex[8]  = '{16'h0000, 0, 0};
    bs[9]  = mk(-5, 0, 16'hFFFF, 0, 0, 0, 1);  ex[9]  = '{16'h8000, 0, 0};
    bs[10] = mk(40, 1, 16'hABCD, 1, 1, 1, 1);  ex[10] = '{16'h8000, 0, 0};
    for (int i = 0; i < 11; i++) begin
      run_single(bs[i], got, lat);
      checks++;
      if (got.p !== ex[i].p || got.inx !== ex[i].inx || got.sat !== ex[i].sat)
        $display("FAIL dir[%0d] got %h/%b/%b want %h/%b/%b", i, got.p, got.inx,
                 got.sat, ex[i].p, ex[i].inx, ex[i].sat);
      else passes++;
      checks++;
      if (lat !== 2) $display("FAIL dir_lat[%0d] got %0d want 2", i, lat);
      else passes++;
    end
  endtask

  task automatic test_random();
    res_t      q[$];
    res_t      e;
    beat_t     b;
    int        n_in = 0;
    int        n_out = 0;
    bit        stall_prev = 1'b0;
    bit [15:0] held_p = '0;
    bit        held_i = 1'b0;
    bit        held_s = 1'b0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_posit !== held_p ||
            out_inexact !== held_i || out_sat !== held_s)
          $display("FAIL rnd_stall got %b/%h want 1/%h", out_valid, out_posit, held_p);
        else passes++;
      end
      b = rand_beat();
      drive(b);
      in_valid  = (n_in < 200) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (c >= 400) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rnd_extra got %h want none", out_posit);
        end else begin
          e = q.pop_front();
          if (out_posit !== e.p || out_inexact !== e.inx || out_sat !== e.sat)
            $display("FAIL rnd[%0d] got %h/%b/%b want %h/%b/%b", n_out, out_posit,
                     out_inexact, out_sat, e.p, e.inx, e.sat);
          else passes++;
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(b));
        n_in++;
      end
      stall_prev = out_valid && !out_ready;
      held_p = out_posit;
      held_i = out_inexact;
      held_s = out_sat;
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0 || n_out != n_in)
      $display("FAIL rnd_drain got %0d out want %0d", n_out, n_in);
    else passes++;
  endtask

  task automatic test_backpressure();
    beat_t     bs[4];
    res_t      q[$];
    res_t      e;
    int        sent = 0;
    int        got = 0;
    int        first_ov = -1;
    int        del[4];
    bit        saw_block = 1'b0;
    bit        stall_prev = 1'b0;
    bit [15:0] held_p = '0;
    for (int i = 0; i < 4; i++) bs[i] = rand_beat();
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_posit !== held_p)
          $display("FAIL bp_stall got %b/%h want 1/%h", out_valid, out_posit, held_p);
        else passes++;
      end
      if (sent < 4) begin
        drive(bs[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (first_ov < 0 && out_valid) first_ov = c;
      out_ready = (first_ov < 0) || (c >= first_ov + 3);
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++;
        if (out_posit !== e.p || out_inexact !== e.inx || out_sat !== e.sat)
          $display("FAIL bp[%0d] got %h want %h", got, out_posit, e.p);
        else passes++;
        del[got] = c;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(bs[sent]));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held_p = out_posit;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (saw_block !== 1'b1) $display("FAIL bp_in_ready got never-low want low");
    else passes++;
    checks++;
    if (got != 4) $display("FAIL bp_count got %0d want 4", got);
    else passes++;
    checks++;
    if (got == 4 && del[3] - del[0] != 3)
      $display("FAIL bp_gap got %0d want 3", del[3] - del[0]);
    else if (got == 4) passes++;
  endtask

  task automatic test_back_to_back();
    beat_t bs[16];
    res_t  q[$];
    res_t  e;
    int    sent = 0;
    int    got = 0;
    int    c_first = -1;
    int    c_last = -1;
    bit    stalled = 1'b0;
    for (int i = 0; i < 16; i++) bs[i] = rand_beat();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 16; c++) begin
      @(negedge clk);
      in_valid = (sent < 16);
      if (sent < 16) drive(bs[sent]);
      #1;
      if (in_valid && !in_ready) stalled = 1'b1;
      if (out_valid) begin
        e = q.pop_front();
        checks++;
        if (out_posit !== e.p || out_inexact !== e.inx || out_sat !== e.sat)
          $display("FAIL b2b[%0d] got %h want %h", got, out_posit, e.p);
        else passes++;
        got++;
        c_last = c;
      end
      if (in_valid && in_ready) begin
        if (c_first < 0) c_first = c;
        q.push_back(model(bs[sent]));
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (stalled !== 1'b0) $display("FAIL b2b_ready got stall want none");
    else passes++;
    checks++;
    if (got != 16 || c_last - c_first != 17)
      $display("FAIL b2b_rate got %0d beats/%0d cyc want 16/17", got, c_last - c_first);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    drive(rand_beat());
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    drive(mk(2, 1, 16'h5555, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL rm_fill got %b want 1", out_valid);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_posit !== 16'h0 || out_inexact !== 1'b0 ||
        out_sat !== 1'b0)
      $display("FAIL rm_clear got %b/%h want 0/0000", out_valid, out_posit);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL rm_ghost got beat want none");
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", in_ready);
    else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
